// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// queue, and redirect handling that drops responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic          run;
  logic          resp_in;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          fire;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_pc;
  logic          unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run              = (state == ST_RUN);
  assign resp_in          = run && imem_resp_valid;
  assign dropping         = (drop_cnt != '0);
  assign push             = resp_in && !dropping && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  assign fire             = imem_req_valid && imem_req_ready;
  assign redirect_pc      = {redirect_addr[31:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr[1:0];

  // A same-cycle pop frees its slot, so the head leaving counts toward the
  // credit; without this a two-entry queue could not stream one per cycle.
  assign occupancy = (CW+1)'(outstanding) + (CW+1)'(count) - (CW+1)'(pop);

  assign imem_req_valid = run && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc;

  assign inst_valid = (count != '0);
  assign inst_data  = q_data[head];
  assign inst_pc    = q_pc[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (state == ST_INIT) begin
      state <= ST_RUN;
    end else if (redirect_valid) begin
      // Every request still in flight belongs to the old path.
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - CW'(resp_in);
      drop_cnt    <= outstanding - CW'(resp_in);
    end else begin
      if (fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(fire) - CW'(resp_in);
      if (resp_in && dropping) drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        tail    <= next_ptr(tail);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) head <= next_ptr(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == CW'(QDEPTH)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// (1-cycle latency, optional response hold).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        hold;
  logic [31:0] pend [$];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic drive_resp();
    imem_resp_valid = !hold && (pend.size() > 0);
    imem_resp_data  = (pend.size() > 0) ? mem(pend[0]) : 32'h0;
  endtask

  task automatic step();
    logic        f;
    logic        consumed;
    logic        was_rst;
    logic [31:0] a;
    f        = imem_req_valid && imem_req_ready;
    a        = imem_req_addr;
    consumed = imem_resp_valid;
    was_rst  = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      pend.delete();
    end else begin
      if (consumed && pend.size() > 0) pend.delete(0);
      if (f) pend.push_back(a);
    end
    drive_resp();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    hold           = 1'b0;
    drive_resp();

    // Reset and the INIT cycle, including an ignored redirect
    step();
    step();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    rst            = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0500;
    #1;
    chk("init_req_valid", 32'(imem_req_valid), 32'd0);
    chk("init_inst_valid", 32'(inst_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;

    // Streaming from RESET_PC
    chk("run0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("run0_req_addr", imem_req_addr, 32'h0);
    step();
    chk("run1_req_addr", imem_req_addr, 32'h4);
    chk("run1_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("run2_inst_valid", 32'(inst_valid), 32'd1);
    chk("run2_inst_pc", inst_pc, 32'h0);
    chk("run2_inst_data", inst_data, mem(32'h0));
    chk("run2_req_addr", imem_req_addr, 32'h8);
    step();
    chk("run3_inst_pc", inst_pc, 32'h4);
    chk("run3_req_addr", imem_req_addr, 32'hC);
    step();
    chk("run4_inst_pc", inst_pc, 32'h8);
    chk("run4_inst_data", inst_data, mem(32'h8));

    // Redirect coinciding with a response and a pop
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0200;
    #1;
    chk("rdp_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rdp_inst_valid", 32'(inst_valid), 32'd0);
    chk("rdp_req_valid2", 32'(imem_req_valid), 32'd1);
    chk("rdp_req_addr", imem_req_addr, 32'h200);
    step();
    chk("rdp_no_stale", 32'(inst_valid), 32'd0);
    step();
    chk("rdp_inst_pc", inst_pc, 32'h200);
    chk("rdp_inst_data", inst_data, mem(32'h200));

    // Fill the queue, then reset mid-operation
    inst_ready = 1'b0;
    #1;
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    chk("full_inst_pc", inst_pc, 32'h200);
    chk("full_req_valid2", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_init_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_init_resp_valid", 32'(imem_resp_valid), 32'd0);
    step();

    // Stalled decode: credits stop issue after two requests
    chk("stall0_req_addr", imem_req_addr, 32'h0);
    chk("stall0_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    chk("stall1_req_addr", imem_req_addr, 32'h4);
    step();
    chk("stall2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall2_inst_pc", inst_pc, 32'h0);
    step();
    chk("stall3_req_valid", 32'(imem_req_valid), 32'd0);
    inst_ready = 1'b1;
    #1;
    chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("resume_req_addr", imem_req_addr, 32'h8);
    step();
    chk("resume_inst_pc1", inst_pc, 32'h4);
    step();
    chk("resume_inst_pc2", inst_pc, 32'h8);

    // Two requests in flight, then an unaligned redirect drops both
    hold = 1'b1;
    drive_resp();
    #1;
    step();
    chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
    chk("hold_inst_valid", 32'(inst_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0103;
    #1;
    chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    hold           = 1'b0;
    drive_resp();
    #1;
    chk("drop_wait_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    chk("drop_req_valid2", 32'(imem_req_valid), 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h100);
    chk("drop_inst_valid1", 32'(inst_valid), 32'd0);
    step();
    chk("drop_inst_valid2", 32'(inst_valid), 32'd0);
    step();
    chk("drop_inst_pc", inst_pc, 32'h100);
    chk("drop_inst_data", inst_data, mem(32'h100));

    // Address wrap at the top of the space
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFF8;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_req_addr1", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_req_addr2", imem_req_addr, 32'h0);
    chk("wrap_inst_pc0", inst_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_inst_pc1", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_inst_pc2", inst_pc, 32'h0);
    chk("wrap_inst_data2", inst_data, mem(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, instruction queue depth and max in-flight credits (legal values 2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  taken control-flow change from the branch stage this cycle.
REQ-006 redirect_addr  input  32  new fetch target (branch-stage jmp_addr).
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  32  request word address.
REQ-010 imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  instruction word.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode accepts instruction.
REQ-014 inst_data  output  32  instruction word at queue head.
REQ-015 inst_pc  output  32  PC of inst_data.

Function
REQ-016 State machine SHALL have two states: INIT (entered on reset, no requests issued) and RUN; INIT->RUN unconditionally on the next cycle after rst deasserts.
REQ-017 Request fires when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (mod 2^32, wraps 32'hFFFF_FFFC->0).
REQ-018 imem_req_addr SHALL equal fetch_pc; imem_req_valid SHALL be asserted only in RUN, with redirect_valid low, and when outstanding + queue_count < QDEPTH.
REQ-019 imem_req_valid, once asserted, SHALL hold with stable address until accepted or a redirect/reset occurs.
REQ-020 Each non-dropped response pushes {resp_pc, imem_resp_data} into the FIFO queue; resp_pc then advances by 4.
REQ-021 Pop on inst_valid && inst_ready; inst_valid = queue non-empty; inst_data/inst_pc show queue head combinationally from registered storage.
REQ-022 Simultaneous push and pop SHALL both take effect; credit rule (REQ-018) guarantees no overflow; push to a full queue is an assertion failure.
REQ-023 outstanding counter: +1 on request fire, -1 on any response (dropped or not), net 0 when both in same cycle.
REQ-024 On redirect_valid (RUN): queue emptied (any same-cycle pop and push discarded), fetch_pc and resp_pc <= {redirect_addr[31:2], 2'b00}, drop_cnt <= outstanding minus 1 if a response arrives that cycle.
REQ-025 While drop_cnt > 0, each response SHALL be discarded and drop_cnt decremented; no queue push.
REQ-026 Redirect while drop_cnt > 0 SHALL reload drop_cnt per REQ-024 (stale responses stay dropped).
REQ-027 Redirect in INIT SHALL be ignored.
REQ-028 Sustained throughput SHALL be one instruction per cycle with 1-cycle memory latency and inst_ready high.

Reset
REQ-029 When rst is high at a clock edge: state=INIT, fetch_pc=resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0.
REQ-030 During and one cycle after reset: imem_req_valid=0, inst_valid=0; responses arriving during those cycles SHALL be ignored.
REQ-031 Reset mid-operation SHALL abandon all in-flight requests; the memory model is reset together with the block.

Verification
REQ-032 Reset release, RESET_PC=0, mem always ready, 1-cycle latency, inst_ready=1 -> req addrs 0,4,8,... every cycle; inst_pc 0,4,8 back-to-back.
REQ-033 inst_ready=0 from start -> exactly QDEPTH (2) requests issued (0,4), then imem_req_valid=0; raising inst_ready resumes with addr 8.
REQ-034 Two requests outstanding (0,4), redirect_valid with addr 32'h100 -> both responses dropped, next inst_pc=32'h100, next req addr 32'h100.
REQ-035 redirect_addr 32'h0000_0103 -> fetch resumes at 32'h0000_0100.
REQ-036 Redirect asserted same cycle as a response and a pop -> queue empty next cycle, drop_cnt = outstanding-1, no stale instruction ever presented.
REQ-037 rst asserted with full queue and requests outstanding -> next cycle inst_valid=0, imem_req_valid=0; fetch restarts at RESET_PC.
